hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Issue controller for the decode stage. Tracks destination registers of in-flight
//  variable-latency loads in a 32-bit scoreboard. Generates ctrl_stall for the decode stage
//  and hold signals for PC and IF/ID on RAW, WAW, load-capacity and drain conditions.
//  Sits beside the decode stage; its stall output feeds the decode stage's control squash.
// PARAMETERS
//  MAX_OUT   4   max loads in flight (1..15); outstanding counter is 4 bits wide
//  CNT_W     16  width of saturating stall-cycle performance counter
// PORTS
//  clk            in   1      core clock
//  rstn           in   1      asynchronous active-low reset
//  id_valid       in   1      decode stage holds a real instruction (0 = bubble)
//  id_rs1         in   5      decode source register 1
//  id_rs2         in   5      decode source register 2
//  id_rd          in   5      decode destination register
//  id_regs_write  in   1      decode instruction writes rd (unsquashed)
//  id_mem_read    in   1      decode instruction is a load (unsquashed)
//  id_mem_write   in   1      decode instruction is a store (rs2 = store data)
//  id_flush       in   1      branch redirect: decode instruction is killed this cycle
//  rsp_valid      in   1      load data returns, written to regfile at this clock edge
//  rsp_rd         in   5      destination of returning load
//  drain_req      in   1      fence: block issue until all loads have returned
//  ctrl_stall     out  1      squash decode controls (insert bubble)
//  pc_hold        out  1      hold PC register
//  ifid_hold      out  1      hold IF/ID register
//  drain_done     out  1      one-cycle pulse: drain complete
//  busy_mask      out  32     scoreboard, bit n = load to xn pending
//  out_cnt        out  4      loads in flight
//  stall_cycles   out  CNT_W  saturating count of cycles with ctrl_stall=1
//  sb_err         out  1      sticky: response for non-pending reg or count underflow
// BEHAVIOUR
//  Reset: busy_mask=0, out_cnt=0, stall_cycles=0, sb_err=0, drain_done=0, state=RUN.
//  Reset mid-operation discards all tracked loads immediately.
//  Hazards are evaluated combinationally from registered busy_mask and out_cnt.
//  Only id_valid=1 with id_flush=0 counts.
//   raw = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]). Checked for every instruction,
//         so a store with pending rs2 stalls.
//   waw = id_regs_write & rd!=0 & busy[rd]
//   cap = id_mem_read & (out_cnt==MAX_OUT)
//  hazard = raw | waw | cap.
//  ctrl_stall = pc_hold = ifid_hold = hazard | (state==DRAIN). All are 0 when id_flush=1.
//  A same-cycle rsp_valid does NOT clear a hazard. The register is written at the edge, so
//  the decode read is valid only next cycle: exactly one stall cycle after the response.
//  Issue = id_valid & ~id_flush & ~ctrl_stall & id_mem_read.
//   On issue: out_cnt+1. If rd!=0, set busy[rd]. Loads to x0 count but never set a bit.
//  Response: clear busy[rsp_rd], out_cnt-1.
//   busy[rsp_rd]=0 with rsp_rd!=0 -> sb_err=1.
//   out_cnt==0 -> sb_err=1, out_cnt stays 0.
//  Issue and response in the same cycle: counter nets to unchanged. Set and clear act on
//  different bits, because waw forbids issuing to a pending rd.
//  FSM:
//   RUN -> STALL when hazard.
//   STALL -> RUN when hazard clears.
//   RUN/STALL -> DRAIN when drain_req=1 and out_cnt!=0. drain_req has priority.
//   DRAIN -> RUN when out_cnt==0 (registered); drain_done=1 for that one cycle.
//   drain_req with out_cnt==0 in RUN: drain_done pulses next cycle, no stall.
//   id_flush in DRAIN keeps DRAIN (loads are never cancelled).
//  stall_cycles increments on every clk with ctrl_stall=1 and saturates at all-ones.
// TESTING
//  1. Load x5 issued; rsp x5 after 3 cycles; next inst add x6,x5,x1
//     -> ctrl_stall for 4 cycles (3 + 1), then issues; busy_mask returns to 0.
//  2. MAX_OUT=4: issue 4 loads to x1..x4, then load x7
//     -> cap stall, out_cnt=4; first rsp -> stall drops next cycle, out_cnt=4 again.
//  3. Store with rs2=x9 pending -> stall; load with rd=x9 pending -> waw stall;
//     load rd=x0 -> out_cnt+1, busy_mask unchanged.
//  4. Hazard active and id_flush=1 -> ctrl_stall=0 that cycle, no issue, no count change.
//  5. drain_req with 2 loads out -> DRAIN, all holds=1 until both rsp,
//     then drain_done pulses once; spurious rsp x12 -> sb_err=1 and sticky.
//  6. rstn low mid-stall with busy_mask=0x0000_0020 -> all outputs 0 asynchronously,
//     state RUN; force stall_cycles near max -> saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks destination registers of in-flight loads and
// raises stall/hold on RAW, WAW, load-capacity and drain conditions.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regs_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_flush,
  input  logic             rsp_valid,
  input  logic [4:0]       rsp_rd,
  input  logic             drain_req,
  output logic             ctrl_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             drain_done,
  output logic [31:0]      busy_mask,
  output logic [3:0]       out_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             sb_err
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

  state_t      state, state_n;
  logic        id_live, raw, waw, cap, hazard, issue;
  logic        drain_set, rsp_dec, rsp_bad;
  logic [31:0] set_vec, clr_vec;

  // Stores need no special case: rs2 is checked for every instruction.
  logic unused_mem_write;
  assign unused_mem_write = id_mem_write;

  always_comb begin
    id_live = id_valid & ~id_flush;
    raw     = ((id_rs1 != 5'd0) & busy_mask[id_rs1]) |
              ((id_rs2 != 5'd0) & busy_mask[id_rs2]);
    waw     = id_regs_write & (id_rd != 5'd0) & busy_mask[id_rd];
    cap     = id_mem_read & (out_cnt == 4'(MAX_OUT));
    hazard  = id_live & (raw | waw | cap);

    ctrl_stall = ~id_flush & (hazard | (state == DRAIN));
    pc_hold    = ctrl_stall;
    ifid_hold  = ctrl_stall;

    issue   = id_live & ~ctrl_stall & id_mem_read;
    set_vec = (issue && id_rd != 5'd0) ? (32'd1 << id_rd) : '0;
    clr_vec = rsp_valid ? (32'd1 << rsp_rd) : '0;
    rsp_dec = rsp_valid & (out_cnt != 4'd0);
    rsp_bad = rsp_valid & (((rsp_rd != 5'd0) & ~busy_mask[rsp_rd]) | (out_cnt == 4'd0));
  end

  always_comb begin
    state_n   = state;
    drain_set = 1'b0;
    case (state)
      RUN, STALL: begin
        if (drain_req && out_cnt != 4'd0) begin
          state_n = DRAIN;
        end else begin
          // An already-empty scoreboard completes the drain without stalling.
          drain_set = drain_req;
          state_n   = hazard ? STALL : RUN;
        end
      end
      DRAIN: begin
        if (out_cnt == 4'd0) begin
          state_n   = RUN;
          drain_set = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      busy_mask    <= '0;
      out_cnt      <= '0;
      stall_cycles <= '0;
      sb_err       <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      state      <= state_n;
      drain_done <= drain_set;
      busy_mask  <= (busy_mask | set_vec) & ~clr_vec;
      out_cnt    <= out_cnt + 4'(issue) - 4'(rsp_dec);
      if (rsp_bad)
        sb_err <= 1'b1;
      if (ctrl_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: RAW latency, capacity, store/WAW,
// flush, drain, error flag, asynchronous reset and counter saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid, id_regs_write, id_mem_read, id_mem_write, id_flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, rsp_rd;
  logic        rsp_valid, drain_req;
  logic        ctrl_stall, pc_hold, ifid_hold, drain_done, sb_err;
  logic [31:0] busy_mask;
  logic [3:0]  out_cnt;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_OUT(4), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regs_write(id_regs_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_flush(id_flush), .rsp_valid(rsp_valid),
    .rsp_rd(rsp_rd), .drain_req(drain_req), .ctrl_stall(ctrl_stall), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .drain_done(drain_done), .busy_mask(busy_mask),
    .out_cnt(out_cnt), .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_regs_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_flush = 0;
    rsp_valid = 0; rsp_rd = 0; drain_req = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
    id_valid = 1; id_mem_read = 1; id_regs_write = 1; id_mem_write = 0;
    id_rd = rd; id_rs1 = rs1; id_rs2 = 0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_mem_read = 0; id_regs_write = 1; id_mem_write = 0;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic set_store(input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_mem_read = 0; id_regs_write = 0; id_mem_write = 1;
    id_rd = 0; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic respond(input logic [4:0] rd);
    rsp_valid = 1; rsp_rd = rd;
  endtask

  task automatic test_reset();
    idle(); rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    #2;
    n_checks++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected %h", busy_mask, 32'h0); end
    n_checks++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", out_cnt); end
    n_checks++; if ({stall_cycles, sb_err, drain_done, ctrl_stall} !== 19'd0) begin n_fail++; $display("FAIL reset_misc: got cycles=%h err=%b done=%b stall=%b expected all 0", stall_cycles, sb_err, drain_done, ctrl_stall); end
    next_cycle();
  endtask

  task automatic test_raw_latency();
    idle(); set_load(5, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL raw_load_issue: got stall=%b expected 0", ctrl_stall); end
    next_cycle();
    n_checks++; if (busy_mask !== 32'h20 || out_cnt !== 4'd1) begin n_fail++; $display("FAIL raw_track: got busy=%h cnt=%0d expected 00000020/1", busy_mask, out_cnt); end
    for (int i = 1; i <= 4; i++) begin
      idle(); set_alu(6, 5, 1);
      if (i == 4) respond(5);
      #2;
      n_checks++; if ({ctrl_stall, pc_hold, ifid_hold} !== 3'b111) begin n_fail++; $display("FAIL raw_stall_%0d: got %b expected 111", i, {ctrl_stall, pc_hold, ifid_hold}); end
      next_cycle();
    end
    idle(); set_alu(6, 5, 1); #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release: got stall=%b expected 0", ctrl_stall); end
    next_cycle();
    n_checks++; if (busy_mask !== 32'h0 || out_cnt !== 4'd0 || stall_cycles !== 16'd4) begin n_fail++; $display("FAIL raw_after: got busy=%h cnt=%0d cycles=%0d expected 0/0/4", busy_mask, out_cnt, stall_cycles); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      idle(); set_load(5'(r), 0); #2;
      n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL cap_fill_%0d: got stall=%b expected 0", r, ctrl_stall); end
      next_cycle();
    end
    n_checks++; if (busy_mask !== 32'h1E || out_cnt !== 4'd4) begin n_fail++; $display("FAIL cap_full: got busy=%h cnt=%0d expected 0000001e/4", busy_mask, out_cnt); end
    idle(); set_load(7, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL cap_stall: got %b expected 1", ctrl_stall); end
    next_cycle();
    idle(); set_load(7, 0); respond(1); #2;
    n_checks++; if (ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL cap_same_cycle_rsp: got %b expected 1", ctrl_stall); end
    next_cycle();
    n_checks++; if (busy_mask !== 32'h1C || out_cnt !== 4'd3) begin n_fail++; $display("FAIL cap_after_rsp: got busy=%h cnt=%0d expected 0000001c/3", busy_mask, out_cnt); end
    idle(); set_load(7, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL cap_release: got %b expected 0", ctrl_stall); end
    next_cycle();
    n_checks++; if (busy_mask !== 32'h9C || out_cnt !== 4'd4) begin n_fail++; $display("FAIL cap_reissue: got busy=%h cnt=%0d expected 0000009c/4", busy_mask, out_cnt); end
    idle(); respond(2); next_cycle();
    idle(); respond(3); next_cycle();
    idle(); respond(4); next_cycle();
    idle(); respond(7); next_cycle();
    n_checks++; if (busy_mask !== 32'h0 || out_cnt !== 4'd0 || sb_err !== 1'b0 || stall_cycles !== 16'd6) begin n_fail++; $display("FAIL cap_drain_out: got busy=%h cnt=%0d err=%b cycles=%0d expected 0/0/0/6", busy_mask, out_cnt, sb_err, stall_cycles); end
  endtask

  task automatic test_store_waw_x0();
    idle(); set_load(9, 0); next_cycle();
    idle(); set_store(0, 9); #2;
    n_checks++; if (ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL store_rs2: got %b expected 1", ctrl_stall); end
    next_cycle();
    idle(); set_load(9, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL waw: got %b expected 1", ctrl_stall); end
    next_cycle();
    n_checks++; if (out_cnt !== 4'd1) begin n_fail++; $display("FAIL waw_no_issue: got cnt=%0d expected 1", out_cnt); end
    idle(); set_load(0, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL x0_load: got %b expected 0", ctrl_stall); end
    next_cycle();
    n_checks++; if (out_cnt !== 4'd2 || busy_mask !== 32'h200) begin n_fail++; $display("FAIL x0_track: got busy=%h cnt=%0d expected 00000200/2", busy_mask, out_cnt); end
    idle(); respond(9); next_cycle();
    idle(); respond(0); next_cycle();
    n_checks++; if (out_cnt !== 4'd0 || busy_mask !== 32'h0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL x0_retire: got busy=%h cnt=%0d err=%b expected 0/0/0", busy_mask, out_cnt, sb_err); end
  endtask

  task automatic test_flush();
    idle(); set_load(5, 0); next_cycle();
    idle(); set_load(6, 5); id_flush = 1; #2;
    n_checks++; if ({ctrl_stall, pc_hold, ifid_hold} !== 3'b000) begin n_fail++; $display("FAIL flush_holds: got %b expected 000", {ctrl_stall, pc_hold, ifid_hold}); end
    next_cycle();
    n_checks++; if (out_cnt !== 4'd1 || busy_mask !== 32'h20 || stall_cycles !== 16'd8) begin n_fail++; $display("FAIL flush_no_issue: got busy=%h cnt=%0d cycles=%0d expected 00000020/1/8", busy_mask, out_cnt, stall_cycles); end
    idle(); respond(5); next_cycle();
  endtask

  task automatic test_drain();
    idle(); set_load(10, 0); next_cycle();
    idle(); set_load(11, 0); next_cycle();
    idle(); drain_req = 1; #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL drain_req_cycle: got %b expected 0", ctrl_stall); end
    next_cycle();
    idle(); #2;
    n_checks++; if ({ctrl_stall, pc_hold, ifid_hold} !== 3'b111) begin n_fail++; $display("FAIL drain_hold: got %b expected 111", {ctrl_stall, pc_hold, ifid_hold}); end
    next_cycle();
    idle(); respond(10); id_flush = 1; #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got %b expected 0", ctrl_stall); end
    next_cycle();
    idle(); respond(11); #2;
    n_checks++; if (ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL drain_kept: got %b expected 1", ctrl_stall); end
    next_cycle();
    idle(); #2;
    n_checks++; if (ctrl_stall !== 1'b1 || drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_last: got stall=%b done=%b expected 1/0", ctrl_stall, drain_done); end
    next_cycle();
    idle(); #2;
    n_checks++; if (ctrl_stall !== 1'b0 || drain_done !== 1'b1) begin n_fail++; $display("FAIL drain_done: got stall=%b done=%b expected 0/1", ctrl_stall, drain_done); end
    next_cycle();
    idle(); #2;
    n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_pulse: got %b expected 0", drain_done); end
    next_cycle();
    idle(); drain_req = 1; #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL empty_drain_stall: got %b expected 0", ctrl_stall); end
    next_cycle();
    idle(); #2;
    n_checks++; if (drain_done !== 1'b1 || ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL empty_drain_done: got done=%b stall=%b expected 1/0", drain_done, ctrl_stall); end
    next_cycle();
    idle(); respond(12); #2;
    n_checks++; if (drain_done !== 1'b0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL pre_spurious: got done=%b err=%b expected 0/0", drain_done, sb_err); end
    next_cycle();
    n_checks++; if (sb_err !== 1'b1 || out_cnt !== 4'd0) begin n_fail++; $display("FAIL spurious_err: got err=%b cnt=%0d expected 1/0", sb_err, out_cnt); end
    idle(); next_cycle(); next_cycle();
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", sb_err); end
  endtask

  task automatic test_async_reset();
    idle(); set_load(5, 0); next_cycle();
    idle(); set_alu(6, 5, 0); #2;
    n_checks++; if (ctrl_stall !== 1'b1 || busy_mask !== 32'h20) begin n_fail++; $display("FAIL pre_reset: got stall=%b busy=%h expected 1/00000020", ctrl_stall, busy_mask); end
    rstn = 0; #1;
    n_checks++; if ({busy_mask, out_cnt, stall_cycles, sb_err, drain_done, ctrl_stall, pc_hold, ifid_hold} !== 57'd0) begin n_fail++; $display("FAIL async_reset: got busy=%h cnt=%0d cycles=%0d err=%b stall=%b expected all 0", busy_mask, out_cnt, stall_cycles, sb_err, ctrl_stall); end
    @(posedge clk); #1 rstn = 1; #2;
    n_checks++; if (ctrl_stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_run: got %b expected 0", ctrl_stall); end
    next_cycle();
  endtask

  task automatic test_saturation();
    idle(); set_load(5, 0); next_cycle();
    idle(); set_alu(6, 5, 0);
    repeat (65534) @(posedge clk);
    #2;
    n_checks++; if (stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_before: got %h expected fffe", stall_cycles); end
    @(posedge clk); #2;
    n_checks++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", stall_cycles); end
    repeat (5) @(posedge clk);
    #2;
    n_checks++; if (stall_cycles !== 16'hFFFF || ctrl_stall !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got cycles=%h stall=%b expected ffff/1", stall_cycles, ctrl_stall); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_latency();
    test_capacity();
    test_store_waw_x0();
    test_flush();
    test_drain();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
